// File: rtl/axis_write_arbiter.sv
// axis_write_arbiter: shares one stream-to-memory adapter between PORTS AXIS
// requesters. Arbitrates transfer commands, latches the winner's address and
// length, sequences the adapter tstart/tdone handshake and routes only the
// owner's stream into the adapter.
// Build option: define ARBITER_FIXED_PRIORITY_EN to make the lowest-index
// requester always win (round-robin when undefined).
module axis_write_arbiter #(
   parameter int PORTS = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int GUARD_CYCLES = 2,
   parameter logic [PORTS-1:0] AXI_LAST_MASK = '0
) (
   input  logic                            aclk,
   input  logic                            resetn,
   input  logic [PORTS-1:0]                r_tstart,
   input  logic [PORTS*ADDR_WIDTH-1:0]     r_taddr,
   input  logic [PORTS*ADDR_WIDTH-1:0]     r_tbytes,
   output logic [PORTS-1:0]                r_tgrant,
   output logic [PORTS-1:0]                r_tdone,
   input  logic [PORTS*DATA_WIDTH-1:0]     r_s_xdata,
   input  logic [PORTS*(DATA_WIDTH/8)-1:0] r_s_xstrb,
   input  logic [PORTS-1:0]                r_s_xlast,
   input  logic [PORTS-1:0]                r_s_xvalid,
   output logic [PORTS-1:0]                r_s_xready,
   output logic                            a_tstart,
   output logic [ADDR_WIDTH-1:0]           a_taddr,
   output logic [ADDR_WIDTH-1:0]           a_tbytes,
   output logic                            a_enableAxiLastSignal,
   input  logic                            a_tdone,
   output logic [DATA_WIDTH-1:0]           a_s_xdata,
   output logic [(DATA_WIDTH/8)-1:0]       a_s_xstrb,
   output logic                            a_s_xlast,
   output logic                            a_s_xvalid,
   input  logic                            a_s_xready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int GW = $clog2(GUARD_CYCLES + 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      GUARD
   } state_t;

   state_t state;
   state_t state_next;

   logic [PW-1:0]         winner;
   logic                  win_found;
   logic [PORTS-1:0]      win_onehot;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [ADDR_WIDTH-1:0] win_bytes;
   logic [PW-1:0]         owner;
   logic [GW-1:0]         guard_cnt;

`ifdef ARBITER_FIXED_PRIORITY_EN
   // Lowest-index requester wins; no fairness state is kept.
   always_comb begin
      winner = '0;
      win_found = 1'b0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (r_tstart[i]) begin
            winner = PW'(i);
            win_found = 1'b1;
         end
      end
   end
`else
   logic [PW-1:0] rr_ptr;
   logic [PW:0]   cand;

   // Search from the pointer upwards, wrapping; the smallest offset wins.
   always_comb begin
      winner = rr_ptr;
      win_found = 1'b0;
      cand = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + (PW+1)'(i);
         if (cand >= (PW+1)'(PORTS)) begin
            cand = cand - (PW+1)'(PORTS);
         end
         if (r_tstart[cand[PW-1:0]]) begin
            winner = cand[PW-1:0];
            win_found = 1'b1;
         end
      end
   end

   // Pointer moves to the port after the most recent winner.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr <= '0;
      end else if (state == IDLE && win_found) begin
         rr_ptr <= (winner == PW'(PORTS - 1)) ? '0 : winner + 1'b1;
      end
   end
`endif

   // Winner's command fields and one-hot grant vector.
   always_comb begin
      win_onehot = '0;
      win_onehot[winner] = 1'b1;
      win_addr = r_taddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      win_bytes = r_tbytes[winner*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // State register.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: zero-length requests complete without leaving IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (win_found && win_bytes != '0) state_next = START;
         START:   state_next = BUSY;
         BUSY:    if (a_tdone) state_next = GUARD;
         GUARD:   if (guard_cnt == GUARD_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command latching, grant/done pulses, adapter start and guard counting.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_tgrant <= '0;
         r_tdone <= '0;
         a_tstart <= 1'b0;
         a_taddr <= '0;
         a_tbytes <= '0;
         a_enableAxiLastSignal <= 1'b0;
         owner <= '0;
         guard_cnt <= '0;
      end else begin
         r_tdone <= '0;
         a_tstart <= (state == START);
         case (state)
            IDLE: begin
               if (win_found) begin
                  a_taddr <= win_addr;
                  a_tbytes <= win_bytes;
                  a_enableAxiLastSignal <= AXI_LAST_MASK[winner];
                  owner <= winner;
                  if (win_bytes == '0) begin
                     r_tdone <= win_onehot;
                     r_tgrant <= '0;
                  end else begin
                     r_tgrant <= win_onehot;
                  end
               end
            end
            BUSY: begin
               if (a_tdone) begin
                  r_tdone <= r_tgrant;
                  r_tgrant <= '0;
                  guard_cnt <= '0;
               end
            end
            GUARD: begin
               guard_cnt <= guard_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Stream mux: only the owner talks to the adapter, and only while BUSY.
   always_comb begin
      a_s_xdata = '0;
      a_s_xstrb = '0;
      a_s_xlast = 1'b0;
      a_s_xvalid = 1'b0;
      r_s_xready = '0;
      if (resetn && state == BUSY) begin
         a_s_xdata = r_s_xdata[owner*DATA_WIDTH +: DATA_WIDTH];
         a_s_xstrb = r_s_xstrb[owner*STRB_WIDTH +: STRB_WIDTH];
         a_s_xlast = r_s_xlast[owner];
         a_s_xvalid = r_s_xvalid[owner];
         r_s_xready[owner] = a_s_xready;
      end
   end

endmodule

// File: doc/axis_write_arbiter.md
Name: axis_write_arbiter

Overview:
Shares one AxisToAxiAdapter instance, used in stream-to-memory (write) direction, between PORTS independent AXIS requesters (e.g. framebuffer writeback, DMA upload).
- Arbitrates transfer commands and latches the winner's address and length.
- Sequences the adapter's tstart/tdone handshake.
- Routes only the granted requester's stream into the adapter's s_x port.
- The adapter's m_x and address channels bypass this block.

Parameters:
PORTS, 4, number of requesters (2..8)
ADDR_WIDTH, 32, address/length width
DATA_WIDTH, 32, stream data width; STRB_WIDTH = DATA_WIDTH/8
GUARD_CYCLES, 2, idle cycles after a_tdone before next a_tstart (min 1)
AXI_LAST_MASK, {PORTS{1'b0}}, per-port value driven on a_enableAxiLastSignal

Ports:
aclk  in  1  clock
resetn  in  1  asynchronous active-low reset
r_tstart  in  PORTS  per-port request, level, held until r_tgrant bit seen
r_taddr  in  PORTS*ADDR_WIDTH  per-port start address
r_tbytes  in  PORTS*ADDR_WIDTH  per-port length in bytes
r_tgrant  out  PORTS  one-hot current owner
r_tdone  out  PORTS  one-cycle completion pulse
r_s_xdata  in  PORTS*DATA_WIDTH  requester stream data
r_s_xstrb  in  PORTS*STRB_WIDTH  requester stream strobes
r_s_xlast  in  PORTS  requester stream last
r_s_xvalid  in  PORTS  requester stream valid
r_s_xready  out  PORTS  requester stream ready
a_tstart  out  1  adapter start pulse
a_taddr  out  ADDR_WIDTH  adapter address, registered
a_tbytes  out  ADDR_WIDTH  adapter length, registered
a_enableAxiLastSignal  out  1  registered AXI_LAST_MASK[owner]
a_tdone  in  1  adapter done pulse
a_s_xdata  out  DATA_WIDTH  muxed data
a_s_xstrb  out  STRB_WIDTH  muxed strobes
a_s_xlast  out  1  muxed last
a_s_xvalid  out  1  muxed valid
a_s_xready  in  1  adapter ready

Behaviour:
- Reset, async on resetn low:
  - State IDLE; r_tgrant, r_tdone, a_tstart, a_taddr, a_tbytes, a_enableAxiLastSignal = 0.
  - Round-robin pointer = port 0.
  - Combinational outputs forced inactive: a_s_xvalid = 0, r_s_xready = 0.
  - Reset mid-transfer aborts silently; no r_tdone is issued.
- States: IDLE -> START -> BUSY -> GUARD -> IDLE. IDLE -> IDLE for zero-length requests.
- IDLE, any r_tstart set at edge N:
  - Winner = first requesting port at or after the pointer, wrapping.
  - Latch winner's r_taddr/r_tbytes into a_taddr/a_tbytes; set r_tgrant one-hot after N; pointer = winner+1 mod PORTS.
  - Zero-length request (r_tbytes == 0): r_tdone[winner] = 1 for exactly the cycle after N; r_tgrant cleared; stay IDLE; adapter never started.
  - Otherwise go to START.
- START: a_tstart = 1 for exactly one cycle, i.e. in the cycle after N+1; then BUSY.
- BUSY, combinational mux:
  - a_s_x* = r_s_x*[owner].
  - r_s_xready[owner] = a_s_xready; all other r_s_xready = 0.
  - Beats from non-owners are never forwarded.
- BUSY, on a_tdone:
  - r_tdone[owner] pulses on the next cycle; r_tgrant cleared on the same edge; enter GUARD.
- GUARD:
  - Count GUARD_CYCLES, then IDLE. Mux is inactive.
  - Requests arriving in GUARD wait.
- a_tdone outside BUSY is ignored.
- r_tstart from the current owner during its own grant is ignored; it must deassert before re-arbitration or it is granted again.
- Simultaneous a_tdone and new requests: completion first, GUARD, then arbitration.
- Arbitration is sampled only in IDLE; at most one outstanding adapter transfer.
- Block is stateless about beat counts; a_tbytes is the adapter's responsibility.

Optional Feature:
ARBITER_FIXED_PRIORITY_EN
- Defined: winner = lowest-index requesting port; pointer unused; a continuously requesting port 0 starves the others.
- Undefined: round-robin as described above.

Test Plan:
1. Port 1 requests taddr 0x1000, tbytes 64 -> r_tgrant = 4'b0010; a_tstart single pulse two cycles after request with a_taddr = 0x1000, a_tbytes = 64; 16 beats from port 1 reach a_s_x*; a_tdone -> r_tdone[1] pulse next cycle; no a_tstart for 2 cycles.
2. All four ports request continuously (tbytes 16) -> grant order 0,1,2,3,0. With ARBITER_FIXED_PRIORITY_EN -> 0,0,0.
3. Port 2 with tbytes 0 -> r_tdone[2] pulse one cycle after grant; a_tstart never asserted; next grant goes to port 3 if it requests.
4. Port 0 owns the adapter while r_s_xvalid[3] = 1 and a_s_xready toggles 1010 -> r_s_xready[3] stays 0; a_s_xdata always equals port 0 data; exactly 16 accepted beats.
5. resetn low in BUSY after 5 beats -> all outputs 0 without a clock edge; no r_tdone. After release, port 2 requests -> granted, a_tstart pulses normally.
